// File: rtl/dff_ram_banked.sv
// dff_ram_banked: single-port flip-flop RAM split into BANKS equal banks,
// with per-lane write masking, registered read data and a read-valid strobe.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   add     in   word address; the upper bits select the bank, the lower bits the row
//   en_n    in   active-low access enable
//   wr_n    in   0 = write, 1 = read
//   wmask   in   per-lane write enable; bit i covers wdata[i*LANE_W +: LANE_W]
//   wdata   in   write data
//   rdata   out  registered read data, held until the next accepted read
//   rvalid  out  one-cycle pulse marking new rdata
//   busy    out  clear sequencer active; accesses are dropped while high
//
// Optional feature macro: DFF_RAM_CLEAR_EN
//   Defined:   after reset, a sequencer zeroes one row of every bank per cycle.
//   Undefined: no sequencer; busy is tied low and storage is undefined until written.
module dff_ram_banked #(
    parameter int WIDTH  = 72,
    parameter int DEPTH  = 8,
    parameter int BANKS  = 2,
    parameter int LANE_W = 9,
    localparam int LANES = WIDTH / LANE_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    add,
    input  logic             en_n,
    input  logic             wr_n,
    input  logic [LANES-1:0] wmask,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy
);

    localparam int BW   = $clog2(BANKS);
    localparam int ROWS = DEPTH / BANKS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW   = (BANKS > 1) ? BW : 1;

    logic [SW-1:0]    bank_sel;
    logic [RW-1:0]    row_sel;
    logic             acc;
    logic             wr_acc;
    logic             rd_acc;
    logic             clr_act;
    logic [RW-1:0]    clr_row;
    logic [WIDTH-1:0] bank_rd [BANKS];
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
    logic             rvalid_q;
    logic             rvalid_d;

    // Address split: bank from the top BW bits, row from the rest.
    if (BANKS > 1) begin : g_bank_sel
        assign bank_sel = add[AW-1 -: BW];
    end else begin : g_one_bank
        assign bank_sel = '0;
    end

    if (ROWS > 1) begin : g_row_sel
        assign row_sel = add[RW-1:0];
    end else begin : g_one_row
        assign row_sel = '0;
    end

`ifdef DFF_RAM_CLEAR_EN
    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t        state_q;
    logic [RW-1:0] cnt_q;
    logic          busy_q;

    // Walks every row once after reset, zeroing that row in all banks
    // at the same time; busy drops on the edge that writes the last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == RW'(ROWS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_act = (state_q == CLEAR);
    assign clr_row = cnt_q;
    assign busy    = busy_q;
`else
    assign clr_act = 1'b0;
    assign clr_row = '0;
    assign busy    = 1'b0;
`endif

    assign acc    = !en_n && !busy;
    assign wr_acc = acc && !wr_n;
    assign rd_acc = acc && wr_n;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem_q [ROWS];
        logic             hit;

        assign hit = (bank_sel == SW'(b));

        // Storage has no reset; only the clear sequencer initialises it.
        always_ff @(posedge clk) begin
            if (clr_act) begin
                mem_q[clr_row] <= '0;
            end else if (wr_acc && hit) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        mem_q[row_sel][l*LANE_W +: LANE_W] <=
                            wdata[l*LANE_W +: LANE_W];
                    end
                end
            end
        end

        assign bank_rd[b] = mem_q[row_sel];
    end

    assign rd_word  = bank_rd[bank_sel];
    assign rdata_d  = rd_acc ? rd_word : rdata_q;
    assign rvalid_d = rd_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
